// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execution units and the writeback arbiter: per-source
// result handshake on one side, register file and flags write ports on the other.
interface wb_arbiter_if #(
  parameter int WORD_SIZE     = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_SOURCES   = 4,
  parameter int NUM_WB_PORTS  = 2
);
  localparam int IW = $clog2(NUM_PHYS_REGS);

  logic                                    flush;
  logic [NUM_SOURCES-1:0]                  src_valid;
  logic [NUM_SOURCES-1:0]                  src_ready;
  logic [NUM_SOURCES-1:0][IW-1:0]          src_index;
  logic [NUM_SOURCES-1:0][WORD_SIZE-1:0]   src_data;
  logic [NUM_SOURCES-1:0]                  src_nzcv_en;
  logic [NUM_SOURCES-1:0][IW-1:0]          src_nzcv_index;
  logic [NUM_SOURCES-1:0][3:0]             src_nzcv;
  logic [NUM_WB_PORTS-1:0]                 wb_en;
  logic [NUM_WB_PORTS-1:0][IW-1:0]         wb_index;
  logic [NUM_WB_PORTS-1:0][WORD_SIZE-1:0]  wb_data;
  logic                                    nzcv_valid;
  logic [IW-1:0]                           nzcv_index;
  logic [3:0]                              nzcv;

  modport master (
    output flush, src_valid, src_index, src_data, src_nzcv_en, src_nzcv_index, src_nzcv,
    input  src_ready, wb_en, wb_index, wb_data, nzcv_valid, nzcv_index, nzcv
  );

  modport slave (
    input  flush, src_valid, src_index, src_data, src_nzcv_en, src_nzcv_index, src_nzcv,
    output src_ready, wb_en, wb_index, wb_data, nzcv_valid, nzcv_index, nzcv
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding NUM_WB_PORTS register file
// write ports plus one flags write port, granted round-robin from registered outputs.
module wb_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_SOURCES   = 4,
  parameter int NUM_WB_PORTS  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_PHYS_REGS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef struct packed {
    logic [IW-1:0]        index;
    logic [WORD_SIZE-1:0] data;
    logic                 nzcv_en;
    logic [IW-1:0]        nzcv_index;
    logic [3:0]           nzcv;
  } entry_t;

  entry_t     mem_reg    [NUM_SOURCES][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg [NUM_SOURCES];
  logic [PW-1:0] rd_ptr_reg [NUM_SOURCES];
  logic [CW-1:0] count_reg  [NUM_SOURCES];
  logic [SW-1:0] rr_ptr_reg, rr_ptr_next;

  entry_t     head     [NUM_SOURCES];
  entry_t     in_entry [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] pop;

  logic [NUM_WB_PORTS-1:0]                wb_en_reg, wb_en_next;
  logic [NUM_WB_PORTS-1:0][IW-1:0]        wb_index_reg, wb_index_next;
  logic [NUM_WB_PORTS-1:0][WORD_SIZE-1:0] wb_data_reg, wb_data_next;
  logic          nzcv_valid_reg, nzcv_valid_next;
  logic [IW-1:0] nzcv_index_reg, nzcv_index_next;
  logic [3:0]    nzcv_reg, nzcv_next;

  int grants;
  int sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign in_entry[gi] = '{index:      bus.src_index[gi],
                              data:       bus.src_data[gi],
                              nzcv_en:    bus.src_nzcv_en[gi],
                              nzcv_index: bus.src_nzcv_index[gi],
                              nzcv:       bus.src_nzcv[gi]};
      assign head[gi] = mem_reg[gi][rd_ptr_reg[gi]];
      // Ready follows the registered count only, so a same-cycle pop never re-opens a full FIFO.
      assign bus.src_ready[gi] = !rst && (count_reg[gi] != CW'(FIFO_DEPTH));
      assign push[gi] = bus.src_valid[gi] && bus.src_ready[gi];
    end
  endgenerate

  // Round-robin scan from rr_ptr; a second flag-writing head is skipped so the scan can still fill ports.
  always_comb begin
    pop             = '0;
    wb_en_next      = '0;
    wb_index_next   = '0;
    wb_data_next    = '0;
    nzcv_valid_next = 1'b0;
    nzcv_index_next = '0;
    nzcv_next       = '0;
    rr_ptr_next     = rr_ptr_reg;
    grants          = 0;
    sel             = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      sel = int'(rr_ptr_reg) + k;
      if (sel >= NUM_SOURCES) sel = sel - NUM_SOURCES;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (s == sel && grants < NUM_WB_PORTS && count_reg[s] != '0 &&
            !(head[s].nzcv_en && nzcv_valid_next)) begin
          pop[s] = 1'b1;
          for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (p == grants) begin
              wb_en_next[p]    = 1'b1;
              wb_index_next[p] = head[s].index;
              wb_data_next[p]  = head[s].data;
            end
          end
          if (head[s].nzcv_en) begin
            nzcv_valid_next = 1'b1;
            nzcv_index_next = head[s].nzcv_index;
            nzcv_next       = head[s].nzcv;
          end
          rr_ptr_next = (s == NUM_SOURCES - 1) ? '0 : SW'(s + 1);
          grants      = grants + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (push[s] && !bus.flush) mem_reg[s][wr_ptr_reg[s]] <= in_entry[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int s = 0; s < NUM_SOURCES; s++) begin
        wr_ptr_reg[s] <= '0;
        rd_ptr_reg[s] <= '0;
        count_reg[s]  <= '0;
      end
      rr_ptr_reg     <= '0;
      wb_en_reg      <= '0;
      wb_index_reg   <= '0;
      wb_data_reg    <= '0;
      nzcv_valid_reg <= 1'b0;
      nzcv_index_reg <= '0;
      nzcv_reg       <= '0;
    end else begin
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (push[s]) wr_ptr_reg[s] <= wr_ptr_reg[s] + 1'b1;
        if (pop[s])  rd_ptr_reg[s] <= rd_ptr_reg[s] + 1'b1;
        count_reg[s] <= count_reg[s] + CW'(push[s]) - CW'(pop[s]);
      end
      rr_ptr_reg     <= rr_ptr_next;
      wb_en_reg      <= wb_en_next;
      wb_index_reg   <= wb_index_next;
      wb_data_reg    <= wb_data_next;
      nzcv_valid_reg <= nzcv_valid_next;
      nzcv_index_reg <= nzcv_index_next;
      nzcv_reg       <= nzcv_next;
    end
  end

  assign bus.wb_en      = wb_en_reg;
  assign bus.wb_index   = wb_index_reg;
  assign bus.wb_data    = wb_data_reg;
  assign bus.nzcv_valid = nzcv_valid_reg;
  assign bus.nzcv_index = nzcv_index_reg;
  assign bus.nzcv       = nzcv_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single result latency, round-robin
// saturation with FIFO-full backpressure, flags conflict, flush and mid-run reset.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.WORD_SIZE(32), .NUM_PHYS_REGS(64), .NUM_SOURCES(4), .NUM_WB_PORTS(2)) bus ();

  wb_arbiter #(
    .WORD_SIZE(32), .NUM_PHYS_REGS(64), .NUM_SOURCES(4), .NUM_WB_PORTS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.flush          = 1'b0;
    bus.src_valid      = '0;
    bus.src_index      = '0;
    bus.src_data       = '0;
    bus.src_nzcv_en    = '0;
    bus.src_nzcv_index = '0;
    bus.src_nzcv       = '0;
  endtask

  task automatic drive_src(input int s, input logic [5:0] idx, input logic [31:0] data,
                           input logic en, input logic [5:0] nidx, input logic [3:0] f);
    bus.src_valid[s]      = 1'b1;
    bus.src_index[s]      = idx;
    bus.src_data[s]       = data;
    bus.src_nzcv_en[s]    = en;
    bus.src_nzcv_index[s] = nidx;
    bus.src_nzcv[s]       = f;
  endtask

  task automatic do_flush;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    tests++; if (bus.src_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", bus.src_ready); end
    tests++; if (bus.wb_en !== 2'b00) begin fails++; $display("FAIL reset_wb_en got %b want 00", bus.wb_en); end
    tests++; if (bus.wb_index !== '0 || bus.wb_data !== '0) begin fails++; $display("FAIL reset_wb_fields got idx %h data %h want 0", bus.wb_index, bus.wb_data); end
    tests++; if (bus.nzcv_valid !== 1'b0 || bus.nzcv_index !== 6'd0 || bus.nzcv !== 4'd0) begin fails++; $display("FAIL reset_nzcv got v%b i%h f%h want 0", bus.nzcv_valid, bus.nzcv_index, bus.nzcv); end
    rst = 1'b0;
    tick();
    tests++; if (bus.src_ready !== 4'b1111) begin fails++; $display("FAIL post_reset_ready got %b want 1111", bus.src_ready); end
  endtask

  task automatic test_single;
    drive_src(0, 6'd5, 32'h0000_DEAD, 1'b0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tests++; if (bus.wb_en !== 2'b00) begin fails++; $display("FAIL single_early got %b want 00", bus.wb_en); end
    tick();
    tests++; if (bus.wb_en !== 2'b01) begin fails++; $display("FAIL single_en got %b want 01", bus.wb_en); end
    tests++; if (bus.wb_index[0] !== 6'd5) begin fails++; $display("FAIL single_idx got %0d want 5", bus.wb_index[0]); end
    tests++; if (bus.wb_data[0] !== 32'h0000_DEAD) begin fails++; $display("FAIL single_data got %h want 0000dead", bus.wb_data[0]); end
    tests++; if (bus.nzcv_valid !== 1'b0) begin fails++; $display("FAIL single_nzcv got %b want 0", bus.nzcv_valid); end
    tick();
    tests++; if (bus.wb_en !== 2'b00) begin fails++; $display("FAIL single_after got %b want 00", bus.wb_en); end
  endtask

  // All sources valid for 8 edges; grants alternate {0,1}/{2,3} and each FIFO holds at most 4.
  task automatic test_round_robin;
    logic [31:0] q [4][$];
    int          seq [4];
    logic [3:0]  rdy;
    logic [3:0]  popm;
    logic [1:0]  exp_en, n_en;
    logic [31:0] exp_data [2];
    logic [31:0] n_data [2];
    int          rr_m, ga, p, last;
    logic [31:0] d;
    do_flush();
    clear_inputs();
    rr_m = 0;
    exp_en = 2'b00;
    for (int s = 0; s < 4; s++) seq[s] = 0;
    for (int c = 0; c < 20; c++) begin
      tests++; if (bus.wb_en !== exp_en) begin fails++; $display("FAIL rr_en c%0d got %b want %b", c, bus.wb_en, exp_en); end
      for (int k = 0; k < 2; k++) begin
        if (exp_en[k]) begin
          tests++;
          if (bus.wb_data[k] !== exp_data[k] || bus.wb_index[k] !== exp_data[k][5:0]) begin
            fails++; $display("FAIL rr_port%0d c%0d got %h/%0d want %h/%0d", k, c, bus.wb_data[k], bus.wb_index[k], exp_data[k], exp_data[k][5:0]);
          end
        end
      end
      for (int s = 0; s < 4; s++) rdy[s] = (q[s].size() != 4);
      tests++; if (bus.src_ready !== rdy) begin fails++; $display("FAIL rr_ready c%0d got %b want %b", c, bus.src_ready, rdy); end
      ga = (rr_m == 0) ? 0 : 2;
      if (q[ga].size() == 0 && q[ga+1].size() == 0) ga = 2 - ga;
      popm = 4'b0000; n_en = 2'b00; p = 0; last = -1;
      for (int s = ga; s < ga + 2; s++) begin
        if (q[s].size() > 0) begin
          popm[s] = 1'b1; n_en[p] = 1'b1; n_data[p] = q[s][0]; p++; last = s;
        end
      end
      if (last >= 0) rr_m = (last + 1) % 4;
      for (int s = 0; s < 4; s++) begin
        d = 32'hA000_0000 | 32'(s << 4) | 32'(seq[s]);
        if (c < 8) drive_src(s, d[5:0], d, 1'b0, 6'd0, 4'd0);
        else bus.src_valid[s] = 1'b0;
      end
      tick();
      for (int s = 0; s < 4; s++) begin
        if (popm[s]) void'(q[s].pop_front());
        if (c < 8 && rdy[s]) begin
          q[s].push_back(32'hA000_0000 | 32'(s << 4) | 32'(seq[s]));
          seq[s]++;
        end
      end
      exp_en = n_en; exp_data[0] = n_data[0]; exp_data[1] = n_data[1];
    end
    clear_inputs();
    tests++; if (seq[3] != 7 || q[3].size() != 0) begin fails++; $display("FAIL rr_lsu_accepts got %0d left %0d want 7 left 0", seq[3], q[3].size()); end
  endtask

  task automatic test_nzcv_conflict;
    do_flush();
    drive_src(0, 6'd10, 32'h111, 1'b1, 6'd20, 4'b1000);
    drive_src(1, 6'd11, 32'h222, 1'b1, 6'd21, 4'b0100);
    drive_src(2, 6'd12, 32'h333, 1'b0, 6'd0,  4'b0000);
    tick();
    clear_inputs();
    tick();
    tests++; if (bus.wb_en !== 2'b11) begin fails++; $display("FAIL nzcv_c1_en got %b want 11", bus.wb_en); end
    tests++; if (bus.wb_index[0] !== 6'd10 || bus.wb_index[1] !== 6'd12) begin fails++; $display("FAIL nzcv_c1_idx got %0d,%0d want 10,12", bus.wb_index[0], bus.wb_index[1]); end
    tests++; if (bus.wb_data[1] !== 32'h333) begin fails++; $display("FAIL nzcv_c1_data got %h want 333", bus.wb_data[1]); end
    tests++; if (bus.nzcv_valid !== 1'b1 || bus.nzcv_index !== 6'd20 || bus.nzcv !== 4'b1000) begin fails++; $display("FAIL nzcv_c1_flags got v%b i%0d f%b want v1 i20 f1000", bus.nzcv_valid, bus.nzcv_index, bus.nzcv); end
    tick();
    tests++; if (bus.wb_en !== 2'b01 || bus.wb_index[0] !== 6'd11) begin fails++; $display("FAIL nzcv_c2_port got %b/%0d want 01/11", bus.wb_en, bus.wb_index[0]); end
    tests++; if (bus.nzcv_valid !== 1'b1 || bus.nzcv_index !== 6'd21 || bus.nzcv !== 4'b0100) begin fails++; $display("FAIL nzcv_c2_flags got v%b i%0d f%b want v1 i21 f0100", bus.nzcv_valid, bus.nzcv_index, bus.nzcv); end
    tick();
    tests++; if (bus.wb_en !== 2'b00 || bus.nzcv_valid !== 1'b0) begin fails++; $display("FAIL nzcv_c3_idle got %b/%b want 00/0", bus.wb_en, bus.nzcv_valid); end
  endtask

  task automatic test_flush;
    do_flush();
    drive_src(2, 6'd1, 32'h44, 1'b0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tick();
    tick();
    drive_src(0, 6'd2, 32'h55, 1'b0, 6'd0, 4'd0);
    drive_src(1, 6'd3, 32'h66, 1'b1, 6'd4, 4'd1);
    drive_src(2, 6'd5, 32'h77, 1'b0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    drive_src(0, 6'd9, 32'h99, 1'b0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tests++; if (bus.wb_en !== 2'b00 || bus.nzcv_valid !== 1'b0) begin fails++; $display("FAIL flush_outputs got %b/%b want 00/0", bus.wb_en, bus.nzcv_valid); end
    tests++; if (bus.src_ready !== 4'b1111) begin fails++; $display("FAIL flush_ready got %b want 1111", bus.src_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.wb_en !== 2'b00) begin fails++; $display("FAIL flush_idle%0d got %b want 00", i, bus.wb_en); end
    end
    drive_src(3, 6'd33, 32'hA3, 1'b0, 6'd0, 4'd0);
    drive_src(1, 6'd17, 32'hA1, 1'b0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tick();
    tests++; if (bus.wb_index[0] !== 6'd17 || bus.wb_index[1] !== 6'd33 || bus.wb_en !== 2'b11) begin fails++; $display("FAIL flush_rr got %b %0d,%0d want 11 17,33", bus.wb_en, bus.wb_index[0], bus.wb_index[1]); end
    tick();
  endtask

  task automatic test_rst_mid;
    for (int s = 0; s < 4; s++) drive_src(s, 6'(40 + s), 32'(s + 1), 1'b1, 6'(s), 4'hF);
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    tests++; if (bus.src_ready !== 4'b0000) begin fails++; $display("FAIL rst_mid_ready got %b want 0000", bus.src_ready); end
    tick();
    rst = 1'b0;
    tests++; if (bus.wb_en !== 2'b00 || bus.wb_index !== '0 || bus.wb_data !== '0) begin fails++; $display("FAIL rst_mid_wb got %b %h %h want 0", bus.wb_en, bus.wb_index, bus.wb_data); end
    tests++; if (bus.nzcv_valid !== 1'b0 || bus.nzcv_index !== 6'd0 || bus.nzcv !== 4'd0) begin fails++; $display("FAIL rst_mid_nzcv got v%b i%0d f%h want 0", bus.nzcv_valid, bus.nzcv_index, bus.nzcv); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (bus.wb_en !== 2'b00 || bus.src_ready !== 4'b1111) begin fails++; $display("FAIL rst_mid_idle%0d got en %b rdy %b want 00 1111", i, bus.wb_en, bus.src_ready); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_nzcv_conflict();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execution units (ALU, FPU, BRU, LSU) and the physical register file. It buffers each unit's results in a small per-source FIFO and grants at most NUM_WB_PORTS results per cycle in round-robin order. It drives the register file write ports and the single NZCV write port from registered outputs. Each unit sees a valid/ready handshake, so it can stall instead of dropping results when writeback bandwidth is short.

## Interface
- WORD_SIZE, reg_pkg::WORD_SIZE: result data width
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS: physical register count; IW = $clog2(NUM_PHYS_REGS)
- NUM_SOURCES, 4: execution units; index 0=ALU, 1=FPU, 2=BRU, 3=LSU
- NUM_WB_PORTS, 2: register file write ports driven per cycle
- FIFO_DEPTH, 4: entries per source FIFO; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered results (branch mispredict recovery)
- src_valid  in  [NUM_SOURCES]  source s presents a result
- src_ready  out  [NUM_SOURCES]  FIFO s can accept
- src_index  in  IW ×NUM_SOURCES  destination physical register
- src_data  in  WORD_SIZE ×NUM_SOURCES  result value
- src_nzcv_en  in  [NUM_SOURCES]  result also writes flags
- src_nzcv_index  in  IW ×NUM_SOURCES  destination flags register
- src_nzcv  in  4 ×NUM_SOURCES  N,Z,C,V
- wb_en  out  [NUM_WB_PORTS]  write port p active
- wb_index  out  IW ×NUM_WB_PORTS  write destination
- wb_data  out  WORD_SIZE ×NUM_WB_PORTS  write value
- nzcv_valid  out  1  flags write active
- nzcv_index  out  IW  flags destination
- nzcv  out  4  flags value

## Operation
- Handshake: source s is accepted on a posedge where src_valid[s] && src_ready[s]. The entry {index, data, nzcv_en, nzcv_index, nzcv} is pushed to FIFO s. Per-source FIFO order is preserved.
- src_ready[s] = !rst && (count[s] != FIFO_DEPTH). It depends only on the registered count; a pop in the same cycle does not raise ready.
- Arbitration runs each cycle, combinationally:
  - Scan sources rr_ptr, rr_ptr+1, … mod NUM_SOURCES.
  - Grant non-empty heads in scan order until NUM_WB_PORTS grants are made.
  - Only one granted head per cycle may have nzcv_en=1. A later head with nzcv_en=1 is skipped, not granted, and the scan continues.
- Port mapping: the k-th grant drives write port k. Ports with no grant have wb_en=0.
- An nzcv_en grant also drives nzcv_valid, nzcv_index and nzcv.
- Granted heads are popped at the posedge.
- rr_ptr becomes (last granted source + 1) mod NUM_SOURCES; it is unchanged if nothing is granted.
- Flush: at the next posedge all counts and pointers go to 0, wb_en and nzcv_valid go to 0, and rr_ptr goes to 0. A handshake in the flush cycle is dropped. Flush has priority over push and pop.
- Upstream rename guarantees no two in-flight results share a destination. The arbiter does no hazard checking.
- Reset: all counts 0, rr_ptr 0, wb_en '0, wb_index '0, wb_data '0, nzcv_valid 0, nzcv_index '0, nzcv '0. src_ready is 0 while rst is high.

## Timing
- Latency: accepted at edge t, granted during cycle t+1, wb_en visible after edge t+1. The minimum is 2 edges from handshake to register file write.
- Throughput: NUM_WB_PORTS results per cycle; at most one result per source per cycle, since only the head of each FIFO can be granted.
- A full FIFO takes ready low for at least one cycle after a pop, because ready follows the registered count.
- All outputs except src_ready are registered and are held at 0 when nothing is granted; outputs never hold stale en=1.
- Reset mid-operation discards all buffered entries with the same effect as a flush. rst has priority over flush.

## Test plan
- Single ALU result idx 5, data 0xDEAD accepted at edge 0 -> wb_en[0]=1, wb_index[0]=5, wb_data[0]=0xDEAD after edge 1; wb_en=0 the cycle after.
- All 4 sources valid every cycle for 8 cycles from rr_ptr 0 -> grants {0,1}, {2,3}, {0,1}, … each cycle. No result is lost or reordered within a source, and each source's src_ready toggles correctly when full.
- ALU and FPU heads both with nzcv_en=1, BRU head plain -> first cycle grants ALU (nzcv_valid=1) and BRU; FPU is granted the next cycle with nzcv_valid=1.
- LSU pushes 4 entries with no grants possible (other sources saturating) -> src_ready[3]=0 with count 4. After one pop, ready stays 0 that cycle and returns to 1 the next.
- Flush asserted with 3 entries buffered and src_valid[0]=1 -> no wb_en in any later cycle, all src_ready=1 next cycle, rr_ptr=0.
- rst asserted for 1 cycle mid-traffic -> all outputs zero the next cycle, src_ready=0 during rst, and buffered entries are never written.
